// File: rtl/pong_ball_ctrl.sv
// Frame-rate ball controller for the pong datapath: moves the ball once per
// screenEnd rising edge, resolves paddle/wall/goal hits and sequences the match.
module pong_ball_ctrl #(
    parameter int XINIT        = 320,
    parameter int YINIT        = 240,
    parameter int XLIM         = 628,
    parameter int YLIM         = 463,
    parameter int XSPEED       = 2,
    parameter int YSPEED       = 1,
    parameter int BALL_W       = 12,
    parameter int BALL_H       = 17,
    parameter int PAD_HW       = 25,
    parameter int PAD_HH       = 33,
    parameter int SEG_TOP      = 200,
    parameter int SEG_BOT      = 280,
    parameter int SERVE_FRAMES = 3,
    parameter int MAX_SCORE    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       start,
    input  logic [9:0] p1_xRef,
    input  logic [8:0] p1_yRef,
    input  logic [9:0] p2_xRef,
    input  logic [8:0] p2_yRef,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [2:0] winner,
    output logic [2:0] game_state,
    output logic       goal_pulse
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        OVER   = 3'd4
    } gameStateType;

    localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0] X_SPEED    = 11'(XSPEED);
    localparam logic [10:0] Y_SPEED    = 11'(YSPEED);
    localparam logic [10:0] X_LIM      = 11'(XLIM);
    localparam logic [10:0] Y_LIM      = 11'(YLIM);
    localparam logic [10:0] B_W        = 11'(BALL_W);
    localparam logic [10:0] B_H        = 11'(BALL_H);
    localparam logic [10:0] P_HW       = 11'(PAD_HW);
    localparam logic [10:0] P_HH       = 11'(PAD_HH);
    localparam logic [10:0] S_TOP      = 11'(SEG_TOP);
    localparam logic [10:0] S_BOT      = 11'(SEG_BOT);
    localparam logic [10:0] P2_BACKOFF = 11'(PAD_HW + 1 + BALL_W);

    localparam logic [9:0]       BALL_X_INIT = 10'(XINIT);
    localparam logic [8:0]       BALL_Y_INIT = 9'(YINIT);
    localparam logic [9:0]       BALL_X_LIM  = 10'(XLIM);
    localparam logic [8:0]       BALL_Y_LIM  = 9'(YLIM);
    localparam logic [CNT_W-1:0] SERVE_LOAD  = CNT_W'(SERVE_FRAMES);
    localparam logic [3:0]       SCORE_END   = 4'(MAX_SCORE);

    gameStateType     state, stateNext;
    logic [9:0]       ballX, ballXNext;
    logic [8:0]       ballY, ballYNext;
    logic             xRight, xRightNext;
    logic             yDown, yDownNext;
    logic [3:0]       p1Score, p1ScoreNext;
    logic [3:0]       p2Score, p2ScoreNext;
    logic [2:0]       winnerReg, winnerNext;
    logic             goalPulse, goalPulseNext;
    logic             p1Scored, p1ScoredNext;
    logic [CNT_W-1:0] serveCnt, serveCntNext;
    logic             screenEndQ;
    logic             tick;

    logic [10:0] x11, y11, p1x, p1y, p2x, p2y, p1Edge, p2HitX;
    logic        p1YHit, p2YHit, inWindow, p1Hit, p2Hit, leftOut, rightOut;
    logic        goal, goalByP1;
    logic [9:0]  xRes;
    logic [8:0]  yRes;
    logic        xRightRes, yDownRes;

    assign tick = screenEnd & ~screenEndQ;

    // Collision resolution for one frame; all sums widened to 11 bits and
    // subtractions moved to the other side so nothing can wrap.
    always_comb begin
        x11 = {1'b0, ballX};
        y11 = {2'b0, ballY};
        p1x = {1'b0, p1_xRef};
        p1y = {2'b0, p1_yRef};
        p2x = {1'b0, p2_xRef};
        p2y = {2'b0, p2_yRef};

        p1Edge   = p1x + P_HW;
        p1YHit   = (y11 <= p1y + P_HH) && (y11 + B_H + P_HH >= p1y);
        p2YHit   = (y11 <= p2y + P_HH) && (y11 + B_H + P_HH >= p2y);
        inWindow = (y11 >= S_TOP) && (y11 <= S_BOT);
        p1Hit    = !xRight && (x11 > p1Edge) && (x11 <= p1Edge + X_SPEED) && p1YHit;
        p2Hit    = xRight && (x11 + B_W + P_HW < p2x)
                   && (x11 + B_W + P_HW + X_SPEED >= p2x) && p2YHit;
        leftOut  = !xRight && (x11 < X_SPEED);
        rightOut = xRight && (x11 + X_SPEED > X_LIM);
        p2HitX   = (p2x - P2_BACKOFF > X_LIM) ? X_LIM : p2x - P2_BACKOFF;

        goal      = 1'b0;
        goalByP1  = 1'b0;
        xRightRes = xRight;
        xRes      = xRight ? 10'(x11 + X_SPEED) : 10'(x11 - X_SPEED);
        if (p1Hit) begin
            xRes      = 10'(p1Edge + 11'd1);
            xRightRes = 1'b1;
        end else if (p2Hit) begin
            xRes      = 10'(p2HitX);
            xRightRes = 1'b0;
        end else if (leftOut) begin
            if (inWindow) begin
                goal = 1'b1;
            end else begin
                xRes      = '0;
                xRightRes = 1'b1;
            end
        end else if (rightOut) begin
            if (inWindow) begin
                goal     = 1'b1;
                goalByP1 = 1'b1;
            end else begin
                xRes      = BALL_X_LIM;
                xRightRes = 1'b0;
            end
        end

        yDownRes = yDown;
        if (!yDown && (y11 < Y_SPEED)) begin
            yRes     = '0;
            yDownRes = 1'b1;
        end else if (yDown && (y11 + Y_SPEED > Y_LIM)) begin
            yRes     = BALL_Y_LIM;
            yDownRes = 1'b0;
        end else begin
            yRes = yDown ? 9'(y11 + Y_SPEED) : 9'(y11 - Y_SPEED);
        end
    end

    always_comb begin
        // NOTE: every next-value gets its hold default first, so no path through the case can infer a latch.
        stateNext     = state;
        ballXNext     = ballX;
        ballYNext     = ballY;
        xRightNext    = xRight;
        yDownNext     = yDown;
        p1ScoreNext   = p1Score;
        p2ScoreNext   = p2Score;
        winnerNext    = winnerReg;
        goalPulseNext = 1'b0;
        p1ScoredNext  = p1Scored;
        serveCntNext  = serveCnt;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext    = SERVE;
                    serveCntNext = SERVE_LOAD;
                    ballXNext    = BALL_X_INIT;
                    ballYNext    = BALL_Y_INIT;
                    xRightNext   = 1'b1;
                    yDownNext    = 1'b0;
                end
            end
            SERVE: begin
                if (tick) begin
                    if (serveCnt == '0) stateNext = PLAY;
                    else serveCntNext = serveCnt - CNT_W'(1);
                end
            end
            PLAY: begin
                if (tick) begin
                    if (goal) begin
                        stateNext     = SCORED;
                        goalPulseNext = 1'b1;
                        p1ScoredNext  = goalByP1;
                    end else begin
                        ballXNext  = xRes;
                        ballYNext  = yRes;
                        xRightNext = xRightRes;
                        yDownNext  = yDownRes;
                    end
                end
            end
            SCORED: begin
                if (p1Scored) p1ScoreNext = p1Score + 4'd1;
                else p2ScoreNext = p2Score + 4'd1;
                if ((p1Scored ? p1ScoreNext : p2ScoreNext) == SCORE_END) begin
                    winnerNext = p1Scored ? 3'd1 : 3'd2;
                    stateNext  = OVER;
                end else begin
                    // Re-serve toward whoever just conceded.
                    stateNext    = SERVE;
                    serveCntNext = SERVE_LOAD;
                    ballXNext    = BALL_X_INIT;
                    ballYNext    = BALL_Y_INIT;
                    xRightNext   = p1Scored;
                    yDownNext    = 1'b0;
                end
            end
            OVER: begin
                if (start) begin
                    stateNext    = SERVE;
                    serveCntNext = SERVE_LOAD;
                    p1ScoreNext  = '0;
                    p2ScoreNext  = '0;
                    winnerNext   = '0;
                    ballXNext    = BALL_X_INIT;
                    ballYNext    = BALL_Y_INIT;
                    xRightNext   = 1'b1;
                    yDownNext    = 1'b0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ballX      <= BALL_X_INIT;
            ballY      <= BALL_Y_INIT;
            xRight     <= 1'b1;
            yDown      <= 1'b0;
            p1Score    <= '0;
            p2Score    <= '0;
            winnerReg  <= '0;
            goalPulse  <= 1'b0;
            p1Scored   <= 1'b0;
            serveCnt   <= '0;
            screenEndQ <= 1'b0;
        end else begin
            state      <= stateNext;
            ballX      <= ballXNext;
            ballY      <= ballYNext;
            xRight     <= xRightNext;
            yDown      <= yDownNext;
            p1Score    <= p1ScoreNext;
            p2Score    <= p2ScoreNext;
            winnerReg  <= winnerNext;
            goalPulse  <= goalPulseNext;
            p1Scored   <= p1ScoredNext;
            serveCnt   <= serveCntNext;
            screenEndQ <= screenEnd;
        end
    end

    assign ball_x     = ballX;
    assign ball_y     = ballY;
    assign p1_score   = p1Score;
    assign p2_score   = p2Score;
    assign winner     = winnerReg;
    assign game_state = state;
    assign goal_pulse = goalPulse;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Self-checking bench for pong_ball_ctrl: directed scenarios plus randomized
// frames/paddles compared every cycle against an integer reference model.
module tb_pong_ball_ctrl;

    localparam int XINIT        = 320;
    localparam int YINIT        = 240;
    localparam int XLIM         = 628;
    localparam int YLIM         = 463;
    localparam int XSPEED       = 2;
    localparam int YSPEED       = 1;
    localparam int BALL_W       = 12;
    localparam int BALL_H       = 17;
    localparam int PAD_HW       = 25;
    localparam int PAD_HH       = 33;
    localparam int SEG_TOP      = 200;
    localparam int SEG_BOT      = 280;
    localparam int SERVE_FRAMES = 3;
    localparam int MAX_SCORE    = 5;

    logic       clock;
    logic       reset;
    logic       screenEnd;
    logic       start;
    logic [9:0] p1_xRef;
    logic [8:0] p1_yRef;
    logic [9:0] p2_xRef;
    logic [8:0] p2_yRef;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [2:0] winner;
    logic [2:0] game_state;
    logic       goal_pulse;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model: plain integers, directions as +1/-1.
    int mState, mX, mY, mDx, mDy, mS1, mS2, mWin, mPulse, mCnt, mSeQ, mScorer;

    pong_ball_ctrl #(
        .XINIT(XINIT), .YINIT(YINIT), .XLIM(XLIM), .YLIM(YLIM),
        .XSPEED(XSPEED), .YSPEED(YSPEED), .BALL_W(BALL_W), .BALL_H(BALL_H),
        .PAD_HW(PAD_HW), .PAD_HH(PAD_HH), .SEG_TOP(SEG_TOP), .SEG_BOT(SEG_BOT),
        .SERVE_FRAMES(SERVE_FRAMES), .MAX_SCORE(MAX_SCORE)
    ) dut (
        .clock(clock), .reset(reset), .screenEnd(screenEnd), .start(start),
        .p1_xRef(p1_xRef), .p1_yRef(p1_yRef), .p2_xRef(p2_xRef), .p2_yRef(p2_yRef),
        .ball_x(ball_x), .ball_y(ball_y), .p1_score(p1_score), .p2_score(p2_score),
        .winner(winner), .game_state(game_state), .goal_pulse(goal_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input int observed, input int expected);
        checksTotal++;
        if (observed == expected) checksPassed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    function automatic bit overlaps(input int y, input int py);
        return (y <= py + PAD_HH) && (y + BALL_H >= py - PAD_HH);
    endfunction

    task automatic modelReset();
        mState = 0; mX = XINIT; mY = YINIT; mDx = 1; mDy = -1;
        mS1 = 0; mS2 = 0; mWin = 0; mPulse = 0; mCnt = 0; mSeQ = 0; mScorer = 0;
    endtask

    task automatic beginServe(input int dir);
        mState = 1; mCnt = SERVE_FRAMES; mX = XINIT; mY = YINIT; mDx = dir; mDy = -1;
    endtask

    task automatic playFrame();
        int p1x, p1y, p2x, p2y, nx, ny, newX, newY, newDx, newDy, scorer;
        bit inWin;
        p1x = int'(p1_xRef); p1y = int'(p1_yRef);
        p2x = int'(p2_xRef); p2y = int'(p2_yRef);
        nx = mX + XSPEED * mDx;
        ny = mY + YSPEED * mDy;
        newX = nx; newDx = mDx; newY = ny; newDy = mDy; scorer = 0;
        inWin = (mY >= SEG_TOP) && (mY <= SEG_BOT);
        if (mDx < 0) begin
            if (nx <= p1x + PAD_HW && mX > p1x + PAD_HW && overlaps(mY, p1y)) begin
                newX = p1x + PAD_HW + 1; newDx = 1;
            end else if (mX < XSPEED) begin
                if (inWin) scorer = 2;
                else begin newX = 0; newDx = 1; end
            end
        end else begin
            if (nx + BALL_W >= p2x - PAD_HW && mX + BALL_W < p2x - PAD_HW && overlaps(mY, p2y)) begin
                newX = p2x - PAD_HW - 1 - BALL_W;
                if (newX > XLIM) newX = XLIM;
                newDx = -1;
            end else if (mX + XSPEED > XLIM) begin
                if (inWin) scorer = 1;
                else begin newX = XLIM; newDx = -1; end
            end
        end
        if (mDy < 0 && mY < YSPEED) begin newY = 0; newDy = 1; end
        else if (mDy > 0 && mY + YSPEED > YLIM) begin newY = YLIM; newDy = -1; end
        if (scorer != 0) begin
            mScorer = scorer; mPulse = 1; mState = 3;
        end else begin
            mX = newX; mY = newY; mDx = newDx; mDy = newDy;
        end
    endtask

    task automatic scoreGoal();
        if (mScorer == 1) begin
            mS1++;
            if (mS1 == MAX_SCORE) begin mWin = 1; mState = 4; end
            else beginServe(1);
        end else begin
            mS2++;
            if (mS2 == MAX_SCORE) begin mWin = 2; mState = 4; end
            else beginServe(-1);
        end
    endtask

    task automatic modelEdge();
        bit tickNow;
        tickNow = screenEnd && (mSeQ == 0);
        mSeQ = int'(screenEnd);
        mPulse = 0;
        case (mState)
            0: if (start) beginServe(1);
            1: if (tickNow) begin
                   if (mCnt == 0) mState = 2;
                   else mCnt--;
               end
            2: if (tickNow) playFrame();
            3: scoreGoal();
            4: if (start) begin mS1 = 0; mS2 = 0; mWin = 0; beginServe(1); end
            default: mState = 0;
        endcase
    endtask

    task automatic compareAll();
        checkVal("ball_x", int'(ball_x), mX);
        checkVal("ball_y", int'(ball_y), mY);
        checkVal("game_state", int'(game_state), mState);
        checkVal("p1_score", int'(p1_score), mS1);
        checkVal("p2_score", int'(p2_score), mS2);
        checkVal("winner", int'(winner), mWin);
        checkVal("goal_pulse", int'(goal_pulse), mPulse);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic runCycle(input logic se, input logic st);
        screenEnd = se;
        start = st;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        compareAll();
    endtask

    task automatic tickFrame();
        runCycle(1'b1, 1'b0);
        runCycle(1'b0, 1'b0);
    endtask

    task automatic startGame();
        runCycle(1'b0, 1'b1);
        for (int i = 0; i < SERVE_FRAMES + 1; i++) tickFrame();
    endtask

    task automatic midCycleReset();
        screenEnd = 1'b0;
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkVal("rst_ball_x", int'(ball_x), 320);
        checkVal("rst_ball_y", int'(ball_y), 240);
        checkVal("rst_p1_score", int'(p1_score), 0);
        checkVal("rst_p2_score", int'(p2_score), 0);
        checkVal("rst_winner", int'(winner), 0);
        checkVal("rst_state", int'(game_state), 0);
        checkVal("rst_goal_pulse", int'(goal_pulse), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic parkPaddles();
        p1_xRef = 10'd1000; p1_yRef = 9'd60;
        p2_xRef = 10'd1000; p2_yRef = 9'd60;
    endtask

    initial begin
        int expX;
        reset = 1'b0;
        screenEnd = 1'b0;
        start = 1'b0;
        parkPaddles();
        modelReset();
        @(negedge clock);
        midCycleReset();

        // Serve sequencing and the first moving frame.
        runCycle(1'b0, 1'b1);
        checkVal("serve_enter", int'(game_state), 1);
        for (int i = 1; i <= 4; i++) begin
            tickFrame();
            checkVal("serve_state", int'(game_state), (i == 4) ? 2 : 1);
            checkVal("serve_hold_x", int'(ball_x), 320);
        end
        tickFrame();
        checkVal("first_move_x", int'(ball_x), 322);
        checkVal("first_move_y", int'(ball_y), 239);

        // A long screenEnd high period yields exactly one move.
        for (int i = 0; i < 5; i++) runCycle(1'b1, 1'b0);
        checkVal("one_tick_x", int'(ball_x), 324);
        checkVal("one_tick_y", int'(ball_y), 238);
        runCycle(1'b0, 1'b1);
        checkVal("start_in_play", int'(game_state), 2);
        tickFrame();
        checkVal("next_tick_x", int'(ball_x), 326);

        // Reset while the ball is in flight.
        midCycleReset();

        // Right-wall bounce outside the goal window, then the ball returns for a p2 goal.
        startGame();
        for (int t = 1; t <= 156; t++) begin
            tickFrame();
            if (t == 154) begin
                checkVal("wall154_x", int'(ball_x), 628);
                checkVal("wall154_y", int'(ball_y), 86);
            end
            if (t == 155) begin
                checkVal("wall155_x", int'(ball_x), 628);
                checkVal("wall155_y", int'(ball_y), 85);
                checkVal("wall155_state", int'(game_state), 2);
            end
            if (t == 156) checkVal("wall156_x", int'(ball_x), 626);
        end
        for (int i = 0; i < 1000 && (mS1 + mS2) == 0; i++) begin
            runCycle(1'b1, 1'b0);
            if (mPulse != 0) begin
                checkVal("goal_pulse_hi", int'(goal_pulse), 1);
                checkVal("goal_scored_state", int'(game_state), 3);
            end
            runCycle(1'b0, 1'b0);
        end
        checkVal("first_goal_p2", int'(p2_score), 1);
        checkVal("first_goal_p1", int'(p1_score), 0);
        checkVal("first_goal_state", int'(game_state), 1);
        checkVal("first_goal_x", int'(ball_x), 320);
        checkVal("first_goal_y", int'(ball_y), 240);

        // Right paddle bounce.
        midCycleReset();
        p2_xRef = 10'd560;
        p2_yRef = 9'd150;
        startGame();
        for (int t = 1; t <= 103; t++) begin
            tickFrame();
            if (t == 102) checkVal("paddle_bounce_x", int'(ball_x), 522);
            if (t == 103) checkVal("paddle_after_x", int'(ball_x), 520);
        end

        // Randomized frames, starts, paddles and occasional resets.
        for (int c = 0; c < 6000; c++) begin
            if ((c % 32) == 0) begin
                if ($urandom_range(0, 3) == 0) parkPaddles();
                else begin
                    p1_xRef = 10'($urandom_range(0, 300));
                    p1_yRef = 9'($urandom_range(0, 511));
                    p2_xRef = 10'($urandom_range(330, 1023));
                    p2_yRef = 9'($urandom_range(0, 511));
                end
            end
            if ($urandom_range(0, 1999) == 0) midCycleReset();
            else runCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        end

        // Full match to game over, then restart.
        parkPaddles();
        midCycleReset();
        runCycle(1'b0, 1'b1);
        for (int c = 0; c < 40000 && mState != 4; c++) runCycle(1'(c % 2 == 0), 1'b0);
        checkVal("reach_over", int'(game_state), 4);
        expX = (mWin == 1) ? XLIM : 0;
        checkVal("over_frozen_x", int'(ball_x), expX);
        checkVal("over_win_score", (mWin == 1) ? int'(p1_score) : int'(p2_score), MAX_SCORE);
        for (int i = 0; i < 6; i++) tickFrame();
        checkVal("over_hold_x", int'(ball_x), expX);
        checkVal("over_hold_state", int'(game_state), 4);
        runCycle(1'b1, 1'b1);
        checkVal("restart_state", int'(game_state), 1);
        checkVal("restart_p1", int'(p1_score), 0);
        checkVal("restart_p2", int'(p2_score), 0);
        checkVal("restart_winner", int'(winner), 0);
        checkVal("restart_x", int'(ball_x), 320);
        checkVal("restart_y", int'(ball_y), 240);
        runCycle(1'b0, 1'b0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
